lv1a_decision: RTL
==================

LV1A_DECISION -- requirements
Module: lv1a_decision

Interface
REQ-001 clk  input  1  system clock; all logic on rising edge.
REQ-002 reset  input  1  synchronous, active-high reset.
REQ-003 in_live  input  1  run-live level; logic active only while high.
REQ-004 in_trig  input  16  raw trigger-condition levels, one bit per source.
REQ-005 in_ext  input  4  external trigger requests, single-cycle pulses.
REQ-006 in_delta  input  1  periodic clock-trigger request, single-cycle pulse.
REQ-007 in_mask  input  16  per-bit enable for in_trig; 1 = enabled.
REQ-008 in_ps_wr  input  1  prescale write strobe.
REQ-009 in_ps_addr  input  4  prescale register index.
REQ-010 in_ps_data  input  16  prescale value.
REQ-011 in_deadtime  input  8  busy length in cycles after an accept.
REQ-012 out_lv1a_raw  output  16  per-bit raw trigger pulses; feeds the raw-accept statistics counter.
REQ-013 out_ext  output  4  in_ext qualified by live, registered.
REQ-014 out_delta  output  1  in_delta qualified by live, registered.
REQ-015 out_lv1a_ps  output  16  per-bit prescaled pulses.
REQ-016 out_lv1a  output  1  accepted level-1 pulse.
REQ-017 out_busy  output  1  deadtime active.
REQ-018 out_nlost  output  32  triggers rejected while busy.

Function
REQ-019 Per-bit rising-edge detect: bit fires when in_trig high this cycle, low previous cycle, in_mask set, in_live high.
REQ-020 out_lv1a_raw, out_ext and out_delta register the qualified requests with 1-cycle latency and are high for one cycle per event.
REQ-021 Each bit has a 16-bit prescale register P and a 16-bit counter C; P = 0 disables the bit; P = 1 passes every raw pulse.
REQ-022 On a raw pulse with P >= 1: if C == P-1, assert the out_lv1a_ps bit next cycle and set C = 0; otherwise C = C+1.
REQ-023 out_lv1a_ps has 2-cycle latency from the sampled in_trig edge.
REQ-024 Trigger request in stage 2 = OR(out_lv1a_ps) OR out_ext != 0 OR out_delta.
REQ-025 With a request and out_busy low, out_lv1a pulses next cycle, giving 3-cycle latency from the in_trig edge.
REQ-026 Busy counter loads in_deadtime on the out_lv1a cycle; out_busy is high while the counter is nonzero; the counter decrements each cycle.
REQ-027 in_deadtime = 0 gives no busy; back-to-back accepts are then allowed.
REQ-028 A request while out_busy is high gives no accept, and out_nlost increments by 1 per request cycle.
REQ-029 out_nlost saturates at 0xFFFFFFFF.
REQ-030 Raw, ext and delta outputs and the prescale counters keep running during busy.
REQ-031 A prescale write sets P[in_ps_addr] = in_ps_data and clears that bit's C in the same cycle.
REQ-032 If a write coincides with a raw pulse on the same bit, the write wins and the pulse does not advance C.
REQ-033 On the in_live 0->1 transition, all C, the busy counter and out_nlost clear. P registers are kept.
REQ-034 While in_live is low, all pulse outputs stay 0 and out_busy is 0.
REQ-035 An in_trig bit held high produces a single pulse; a re-fire requires a low cycle.

Reset
REQ-036 reset clears all outputs, all C, the busy counter, out_nlost and the edge-detect history to 0.
REQ-037 reset sets all P to 1.
REQ-038 reset dominates a simultaneous in_ps_wr.
REQ-039 reset in mid-deadtime drops out_busy on the next cycle.

Verification
REQ-040 Live high, mask=0x0001, P=1, single edge on in_trig[0] at cycle 10 -> out_lv1a_raw=0x0001 at cycle 11, out_lv1a_ps=0x0001 at 12, out_lv1a at 13.
REQ-041 P[3]=4, eight edges on bit 3 -> eight raw pulses, two ps pulses (on the 4th and 8th edge).
REQ-042 in_deadtime=5, requests at cycles 0, 2 and 6 of the stage-2 timeline -> accepts at 1 and 7, out_nlost=1.
REQ-043 in_live dropped and re-raised after out_nlost=7 with C[3]=2 -> out_nlost=0, C[3]=0, P[3] unchanged.
REQ-044 in_trig[0] held high for 20 cycles -> exactly one raw pulse; mask=0 -> none.
REQ-045 reset asserted during busy with in_ps_wr active -> all outputs 0 next cycle, P=1 for every bit.

Source files
------------

// File: rtl/lv1a_decision_if.sv
// Trigger-decision bus: the live level, the trigger sources, the prescale programming port
// and every decision output, grouped so the environment and the decision block share one bundle.
interface lv1a_decision_if;
  logic        in_live;
  logic [15:0] in_trig;
  logic [3:0]  in_ext;
  logic        in_delta;
  logic [15:0] in_mask;
  logic        in_ps_wr;
  logic [3:0]  in_ps_addr;
  logic [15:0] in_ps_data;
  logic [7:0]  in_deadtime;
  logic [15:0] out_lv1a_raw;
  logic [3:0]  out_ext;
  logic        out_delta;
  logic [15:0] out_lv1a_ps;
  logic        out_lv1a;
  logic        out_busy;
  logic [31:0] out_nlost;

  modport master (
    output in_live, in_trig, in_ext, in_delta, in_mask,
           in_ps_wr, in_ps_addr, in_ps_data, in_deadtime,
    input  out_lv1a_raw, out_ext, out_delta, out_lv1a_ps,
           out_lv1a, out_busy, out_nlost
  );

  modport slave (
    input  in_live, in_trig, in_ext, in_delta, in_mask,
           in_ps_wr, in_ps_addr, in_ps_data, in_deadtime,
    output out_lv1a_raw, out_ext, out_delta, out_lv1a_ps,
           out_lv1a, out_busy, out_nlost
  );
endinterface

// File: rtl/lv1a_decision.sv
// Level-1 accept decision: edge-detects the trigger sources, prescales each one, ORs in the
// external and periodic requests, and accepts them subject to a programmable deadtime.
module lv1a_decision (
  input logic             clk,
  input logic             reset,
  lv1a_decision_if.slave  bus
);
  localparam int NBITS = 16;

  logic [15:0] trig_prev;
  logic        live_prev;
  logic [15:0] raw_q;
  logic [3:0]  ext_q;
  logic        delta_q;
  logic [15:0] ps_q;
  logic        lv1a_q;
  logic [7:0]  busy_cnt;
  logic [31:0] nlost_q;
  logic [15:0] ps_val [NBITS];
  logic [15:0] ps_cnt [NBITS];

  logic [15:0] raw_fire;
  logic [15:0] ps_step;
  logic [15:0] ps_wr_hit;
  logic [15:0] ps_hit;
  logic        live_rise;
  logic        busy;
  logic        request;

  always_comb begin
    // NOTE: every combinational output gets a default first, so no path can infer a latch.
    ps_step   = '0;
    ps_wr_hit = '0;
    ps_hit    = '0;
    raw_fire  = bus.in_trig & ~trig_prev & bus.in_mask & {NBITS{bus.in_live}};
    live_rise = bus.in_live & ~live_prev;
    busy      = (busy_cnt != 8'd0);
    request   = (|ps_q) | (|ext_q) | delta_q;
    for (int i = 0; i < NBITS; i++) begin
      ps_wr_hit[i] = bus.in_ps_wr && (bus.in_ps_addr == 4'(i));
      ps_step[i]   = bus.in_live && raw_q[i] && (ps_val[i] != 16'd0);
      // A programming write to this bit swallows a coincident pulse.
      ps_hit[i]    = ps_step[i] && (ps_cnt[i] == ps_val[i] - 16'd1) && !ps_wr_hit[i];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      trig_prev <= '0;
      live_prev <= 1'b0;
      raw_q     <= '0;
      ext_q     <= '0;
      delta_q   <= 1'b0;
      ps_q      <= '0;
      lv1a_q    <= 1'b0;
      busy_cnt  <= '0;
      nlost_q   <= '0;
      // NOTE: the prescale arrays are 32 small flop registers, not RAM, so they take a reset.
      for (int i = 0; i < NBITS; i++) begin
        ps_val[i] <= 16'd1;
        ps_cnt[i] <= '0;
      end
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      trig_prev <= bus.in_trig;
      live_prev <= bus.in_live;
      raw_q     <= raw_fire;
      ext_q     <= bus.in_ext & {4{bus.in_live}};
      delta_q   <= bus.in_delta & bus.in_live;
      ps_q      <= ps_hit;
      lv1a_q    <= bus.in_live && request && !busy;

      for (int i = 0; i < NBITS; i++) begin
        if (ps_wr_hit[i]) begin
          ps_val[i] <= bus.in_ps_data;
          ps_cnt[i] <= '0;
        end else if (live_rise || ps_hit[i]) begin
          ps_cnt[i] <= '0;
        end else if (ps_step[i]) begin
          ps_cnt[i] <= ps_cnt[i] + 16'd1;
        end
      end

      // Holding the deadtime at zero while not live keeps out_busy low and cleared for the next run.
      if (!bus.in_live) begin
        busy_cnt <= '0;
      end else if (request && !busy) begin
        busy_cnt <= bus.in_deadtime;
      end else if (busy) begin
        busy_cnt <= busy_cnt - 8'd1;
      end

      if (live_rise) begin
        nlost_q <= '0;
      end else if (bus.in_live && request && busy && (nlost_q != 32'hFFFF_FFFF)) begin
        nlost_q <= nlost_q + 32'd1;
      end
    end
  end

  assign bus.out_lv1a_raw = raw_q;
  assign bus.out_ext      = ext_q;
  assign bus.out_delta    = delta_q;
  assign bus.out_lv1a_ps  = ps_q;
  assign bus.out_lv1a     = lv1a_q;
  assign bus.out_busy     = busy;
  assign bus.out_nlost    = nlost_q;
endmodule
